// File: rtl/multicycle_control.sv
// Multicycle RISC-style main control FSM.
// Optional MULTICYCLE_CONTROL_INSTR_COUNT_EN adds a retired-instruction counter.
module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic [2:0] UnitControlRequest,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       RegWrite,
  output logic [1:0] WbSel,
  output logic [3:0] State,
  output logic       IllegalOp
`ifdef MULTICYCLE_CONTROL_INSTR_COUNT_EN
  ,
  output logic [31:0] InstrCount
`endif
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    EXEC_I   = 4'd10,
    I_WB     = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t state;
  state_t nxt;
  logic   illegal_d;

  assign State = state;

  // State and illegal-opcode pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      IllegalOp <= 1'b0;
    end else begin
      state     <= nxt;
      IllegalOp <= illegal_d;
    end
  end

  // Next state and Moore outputs; everything held low while in reset
  always_comb begin
    nxt                = state;
    illegal_d          = 1'b0;
    UnitControlRequest = 3'b000;
    ALUSrcA            = 1'b0;
    ALUSrcB            = 2'b00;
    PCWrite            = 1'b0;
    PCWriteCond        = 1'b0;
    PCSource           = 2'b00;
    IRWrite            = 1'b0;
    MemRead            = 1'b0;
    MemWrite           = 1'b0;
    IorD               = 1'b0;
    RegWrite           = 1'b0;
    WbSel              = 2'b00;
    if (rst_n) begin
      unique case (state)
        FETCH: begin
          MemRead            = 1'b1;
          ALUSrcB            = 2'b01;
          UnitControlRequest = 3'b001;
          IRWrite            = MemReady;
          PCWrite            = MemReady;
          if (MemReady) nxt = DECODE;
        end
        DECODE: begin
          ALUSrcB            = 2'b11;
          UnitControlRequest = 3'b001;
          unique case (1'b1)
            (Opcode == OP_R):    nxt = EXEC_R;
            (Opcode == OP_LW),
            (Opcode == OP_SW):   nxt = MEM_ADDR;
            (Opcode == OP_BEQ):  nxt = BRANCH;
            (Opcode == OP_J):    nxt = JUMP;
            (Opcode == OP_ADDI): nxt = EXEC_I;
            default: begin
              nxt       = FETCH;
              illegal_d = 1'b1;
            end
          endcase
        end
        MEM_ADDR: begin
          ALUSrcA            = 1'b1;
          ALUSrcB            = 2'b10;
          UnitControlRequest = 3'b001;
          if (Opcode == OP_LW)      nxt = MEM_RD;
          else if (Opcode == OP_SW) nxt = MEM_WR;
          else                      nxt = FETCH;
        end
        MEM_RD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          if (MemReady) nxt = MEM_WB;
        end
        MEM_WB: begin
          RegWrite = 1'b1;
          WbSel    = 2'b01;
          nxt      = FETCH;
        end
        MEM_WR: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
          if (MemReady) nxt = FETCH;
        end
        EXEC_R: begin
          ALUSrcA = 1'b1;
          nxt     = R_WB;
        end
        R_WB: begin
          RegWrite = 1'b1;
          nxt      = FETCH;
        end
        BRANCH: begin
          ALUSrcA            = 1'b1;
          UnitControlRequest = 3'b010;
          PCWriteCond        = 1'b1;
          PCSource           = 2'b01;
          nxt                = FETCH;
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
          nxt      = FETCH;
        end
        EXEC_I: begin
          ALUSrcA            = 1'b1;
          ALUSrcB            = 2'b10;
          UnitControlRequest = 3'b001;
          nxt                = I_WB;
        end
        I_WB: begin
          RegWrite = 1'b1;
          WbSel    = 2'b10;
          nxt      = FETCH;
        end
        default: nxt = FETCH;
      endcase
    end
  end

`ifdef MULTICYCLE_CONTROL_INSTR_COUNT_EN
  logic [31:0] instr_count;
  logic        retire;

  assign InstrCount = instr_count;

  // An instruction retires when a final state hands back to FETCH
  always_comb begin
    retire = 1'b0;
    if (rst_n && nxt == FETCH) begin
      unique case (state)
        R_WB, MEM_WB, MEM_WR,
        I_WB, BRANCH, JUMP: retire = 1'b1;
        default:            retire = 1'b0;
      endcase
    end
  end

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_count <= 32'd0;
    else if (retire) instr_count <= instr_count + 32'd1;
  end
`endif

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports in the order listed in REQ-002 to REQ-019.
REQ-002 clk  in  1  Rising-edge clock.
REQ-003 rst_n  in  1  Asynchronous active-low reset.
REQ-004 Opcode  in  6  Instruction opcode from the instruction register; stable from DECODE onward.
REQ-005 MemReady  in  1  Memory access completes this cycle.
REQ-006 UnitControlRequest  out  3  ALU request to ALU control: 000 R-type (use funct), 001 add, 010 sub.
REQ-007 ALUSrcA  out  1  0 = PC, 1 = register A.
REQ-008 ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
REQ-009 PCWrite  out  1  Unconditional PC load.
REQ-010 PCWriteCond  out  1  PC load when ALU Zero is set.
REQ-011 PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-012 IRWrite  out  1  Instruction register load.
REQ-013 MemRead  out  1  Memory read strobe.
REQ-014 MemWrite  out  1  Memory write strobe.
REQ-015 IorD  out  1  Memory address select: 0 = PC, 1 = ALUOut.
REQ-016 RegWrite  out  1  Register file write.
REQ-017 WbSel  out  2  Write-back select: 00 = ALUOut to rd, 01 = MDR to rt, 10 = ALUOut to rt.
REQ-018 State  out  4  Current state encoding.
REQ-019 IllegalOp  out  1  One-cycle pulse on an unsupported opcode.

Function
REQ-020 The FSM SHALL use these state encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC_R=6, R_WB=7, BRANCH=8, JUMP=9, EXEC_I=10, I_WB=11.
REQ-021 Control outputs SHALL be Moore-decoded from State, except MemReady qualification in REQ-022; any output not listed for a state SHALL be 0.
REQ-022 In FETCH the block SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01 and request 001, with IRWrite=PCWrite=MemReady and PCSource=00; it SHALL stay in FETCH until MemReady, then go to DECODE.
REQ-023 In DECODE the block SHALL drive ALUSrcA=0, ALUSrcB=11 and request 001, then branch on Opcode: 000000 to EXEC_R, 100011 or 101011 to MEM_ADDR, 000100 to BRANCH, 000010 to JUMP, 001000 to EXEC_I, any other value to FETCH.
REQ-024 In MEM_ADDR and EXEC_I the block SHALL drive ALUSrcA=1, ALUSrcB=10 and request 001; MEM_ADDR SHALL go to MEM_RD for 100011 and to MEM_WR for 101011, and EXEC_I SHALL go to I_WB.
REQ-025 In MEM_RD the block SHALL drive MemRead=1, IorD=1 and wait for MemReady, then go to MEM_WB.
REQ-026 In MEM_WR the block SHALL drive MemWrite=1, IorD=1 and wait for MemReady, then go to FETCH.
REQ-027 In EXEC_R the block SHALL drive ALUSrcA=1, ALUSrcB=00 and request 000, then go to R_WB.
REQ-028 In BRANCH the block SHALL drive ALUSrcA=1, ALUSrcB=00, request 010, PCWriteCond=1 and PCSource=01, then go to FETCH.
REQ-029 In JUMP the block SHALL drive PCWrite=1 and PCSource=10, then go to FETCH.
REQ-030 R_WB, MEM_WB and I_WB SHALL drive RegWrite=1 with WbSel 00, 01 and 10 respectively, then go to FETCH.
REQ-031 IllegalOp SHALL be a registered pulse, high for exactly the one cycle after DECODE sees an unsupported opcode.
REQ-032 State encodings 12 to 15 SHALL drive all outputs to 0 and go to FETCH on the next edge.
REQ-033 Instruction latency SHALL be 3 cycles (jump, branch), 4 cycles (R-type, addi, sw) and 5 cycles (lw), plus one cycle for each MemReady-low wait cycle.

Reset
REQ-034 While rst_n is low, State SHALL be 0 (FETCH), IllegalOp 0, InstrCount 0, and every control output 0, including the FETCH strobes, which are gated by rst_n.
REQ-035 Assertion of rst_n mid-instruction, including during memory waits, SHALL abort the instruction with no further strobes.
REQ-036 After rst_n deasserts, the first rising edge SHALL evaluate from FETCH.

Configuration
REQ-037 With macro MULTICYCLE_CONTROL_INSTR_COUNT_EN defined, the block SHALL add output port InstrCount (out, 32 bits).
REQ-038 InstrCount SHALL increment by 1, wrapping from 0xFFFFFFFF to 0, on each transition to FETCH from R_WB, MEM_WB, MEM_WR (when MemReady), I_WB, BRANCH or JUMP, and not on an illegal-opcode return.
REQ-039 Without the macro, the port and the counter SHALL be absent and all other behaviour identical.

Verification
REQ-040 Bench: R-type (Opcode 000000), MemReady=1 -> State 0,1,6,7,0; request 000 in EXEC_R; RegWrite=1 with WbSel=00 for exactly one cycle.
REQ-041 Bench: lw (100011) with MemReady low for 2 cycles in MEM_RD -> MEM_RD held 3 cycles; MemRead=IorD=1 throughout; then MEM_WB with WbSel=01; 7 cycles total.
REQ-042 Bench: beq (000100) -> BRANCH drives request 010, PCWriteCond=1, PCSource=01; jump (000010) -> PCWrite=1, PCSource=10; both return to FETCH.
REQ-043 Bench: Opcode 111111 -> DECODE goes to FETCH, IllegalOp high for one cycle, no RegWrite or MemWrite, InstrCount unchanged.
REQ-044 Bench: rst_n low asynchronously in MEM_WR -> outputs 0 immediately with no clock edge; after release, State=0 and InstrCount=0.
REQ-045 Bench (MULTICYCLE_CONTROL_INSTR_COUNT_EN): preload InstrCount to 0xFFFFFFFF via forced state, retire one addi -> InstrCount=0.
